wishbone_arbiter_2x1: RTL and testbench

Two-master, one-slave Wishbone arbiter that shares a single Wishbone slave, typically `single_port_ram`, between two requesters such as instruction fetch and load/store. Each requester holds the bus for a complete `cyc` cycle, so a multi-cycle slave (`BUSY_CYCLES` > 0) is never interleaved. Default policy is round-robin with a registered grant. The block sits between the core's memory ports and the RAM instance in the top-level memory subsystem.

---
 rtl/wishbone_arbiter_2x1_if.sv | 31 +++
 rtl/wishbone_arbiter_2x1.sv | 158 +++++++++++++++
 tb/tb_wishbone_arbiter_2x1.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_arbiter_2x1_if.sv
// wishbone_if: point-to-point Wishbone classic bundle.
//   master modport drives cyc/stb/we/tgd/sel/addr/dat_o_p and receives dat_i_p/ack.
//   slave modport is the mirror image.
// Parameters: DATA_SIZE (data width), BYTE_SIZE (sel granule), ADDR_SIZE (address width).
interface wishbone_if #(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8,
  parameter int ADDR_SIZE = 32
);
  localparam int SEL_SIZE = DATA_SIZE / BYTE_SIZE;

  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic                 tgd;
  logic [SEL_SIZE-1:0]  sel;
  logic [ADDR_SIZE-1:0] addr;
  logic [DATA_SIZE-1:0] dat_o_p;
  logic [DATA_SIZE-1:0] dat_i_p;
  logic                 ack;

  modport master (
    output cyc, stb, we, tgd, sel, addr, dat_o_p,
    input  dat_i_p, ack
  );

  modport slave (
    input  cyc, stb, we, tgd, sel, addr, dat_o_p,
    output dat_i_p, ack
  );
endinterface

// File: rtl/wishbone_arbiter_2x1.sv
// wishbone_arbiter_2x1: shares one Wishbone slave between two requesters.
// A requester keeps the bus for its whole cyc; every release is followed by
// one IDLE turnaround cycle. Ties are broken round-robin using last_q.
//
// Build option: define WB_ARBITER_FIXED_PRIORITY_EN to drop last_q and let
// s0 always win ties (s1 may starve).
//
// Ports:
//   clock     rising-edge clock
//   reset_n   asynchronous active-low reset
//   wb_if_s0  requester 0 (slave modport)
//   wb_if_s1  requester 1 (slave modport)
//   wb_if_m   shared slave side (master modport)
//   grant     one-hot owner: 01 = s0, 10 = s1, 00 = none
//
// state | meaning
// IDLE  | no owner, master outputs forced to 0, arbitration this cycle
// GNT0  | s0 owns the bus until it drops cyc
// GNT1  | s1 owns the bus until it drops cyc
module wishbone_arbiter_2x1 #(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8,
  parameter int ADDR_SIZE = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  wishbone_if.slave   wb_if_s0,
  wishbone_if.slave   wb_if_s1,
  wishbone_if.master  wb_if_m,
  output logic [1:0]  grant
);
  localparam int SEL_SIZE = DATA_SIZE / BYTE_SIZE;

  // Encoding matches grant directly so grant is a pure register output.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  state_e state_q, state_d;

`ifndef WB_ARBITER_FIXED_PRIORITY_EN
  logic last_q, last_d;
`endif

  logic                 m_cyc, m_stb, m_we, m_tgd;
  logic [SEL_SIZE-1:0]  m_sel;
  logic [ADDR_SIZE-1:0] m_addr;
  logic [DATA_SIZE-1:0] m_dat;
  logic                 ack0, ack1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
`ifndef WB_ARBITER_FIXED_PRIORITY_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
`ifndef WB_ARBITER_FIXED_PRIORITY_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
`ifndef WB_ARBITER_FIXED_PRIORITY_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (wb_if_s0.cyc && wb_if_s1.cyc) begin
`ifdef WB_ARBITER_FIXED_PRIORITY_EN
          state_d = GNT0;
`else
          // last_q = 1 means s1 was served most recently, so s0 goes next.
          state_d = last_q ? GNT0 : GNT1;
`endif
        end else if (wb_if_s0.cyc) begin
          state_d = GNT0;
        end else if (wb_if_s1.cyc) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!wb_if_s0.cyc) begin
          state_d = IDLE;
`ifndef WB_ARBITER_FIXED_PRIORITY_EN
          last_d  = 1'b0;
`endif
        end
      end
      GNT1: begin
        if (!wb_if_s1.cyc) begin
          state_d = IDLE;
`ifndef WB_ARBITER_FIXED_PRIORITY_EN
          last_d  = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Mux is keyed off the state register, so an async reset drops the
  // master-side cyc/stb immediately.
  always_comb begin
    m_cyc  = 1'b0;
    m_stb  = 1'b0;
    m_we   = 1'b0;
    m_tgd  = 1'b0;
    m_sel  = '0;
    m_addr = '0;
    m_dat  = '0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    case (state_q)
      GNT0: begin
        m_cyc  = wb_if_s0.cyc;
        m_stb  = wb_if_s0.stb;
        m_we   = wb_if_s0.we;
        m_tgd  = wb_if_s0.tgd;
        m_sel  = wb_if_s0.sel;
        m_addr = wb_if_s0.addr;
        m_dat  = wb_if_s0.dat_o_p;
        ack0   = wb_if_m.ack;
      end
      GNT1: begin
        m_cyc  = wb_if_s1.cyc;
        m_stb  = wb_if_s1.stb;
        m_we   = wb_if_s1.we;
        m_tgd  = wb_if_s1.tgd;
        m_sel  = wb_if_s1.sel;
        m_addr = wb_if_s1.addr;
        m_dat  = wb_if_s1.dat_o_p;
        ack1   = wb_if_m.ack;
      end
      default: ;
    endcase
  end

  assign wb_if_m.cyc      = m_cyc;
  assign wb_if_m.stb      = m_stb;
  assign wb_if_m.we       = m_we;
  assign wb_if_m.tgd      = m_tgd;
  assign wb_if_m.sel      = m_sel;
  assign wb_if_m.addr     = m_addr;
  assign wb_if_m.dat_o_p  = m_dat;

  assign wb_if_s0.ack     = ack0;
  assign wb_if_s1.ack     = ack1;
  assign wb_if_s0.dat_i_p = wb_if_m.dat_i_p;
  assign wb_if_s1.dat_i_p = wb_if_m.dat_i_p;

  assign grant = state_q;
endmodule

// File: tb/tb_wishbone_arbiter_2x1.sv
// Testbench for wishbone_arbiter_2x1 with a small busy-cycle RAM model as slave.
module tb_wishbone_arbiter_2x1;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int AW = 32;
  localparam int SW = DW / BW;
  localparam int BUSY_CYCLES = 6;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] grant;

  always #5 clock = ~clock;

  wishbone_if #(.DATA_SIZE(DW), .BYTE_SIZE(BW), .ADDR_SIZE(AW)) s0_if ();
  wishbone_if #(.DATA_SIZE(DW), .BYTE_SIZE(BW), .ADDR_SIZE(AW)) s1_if ();
  wishbone_if #(.DATA_SIZE(DW), .BYTE_SIZE(BW), .ADDR_SIZE(AW)) m_if ();

  wishbone_arbiter_2x1 #(.DATA_SIZE(DW), .BYTE_SIZE(BW), .ADDR_SIZE(AW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .wb_if_s0 (s0_if),
    .wb_if_s1 (s1_if),
    .wb_if_m  (m_if),
    .grant    (grant)
  );

  // requester drive
  logic          r_cyc [2];
  logic          r_stb [2];
  logic          r_we  [2];
  logic [SW-1:0] r_sel [2];
  logic [AW-1:0] r_addr[2];
  logic [DW-1:0] r_dat [2];

  assign s0_if.cyc = r_cyc[0];  assign s1_if.cyc = r_cyc[1];
  assign s0_if.stb = r_stb[0];  assign s1_if.stb = r_stb[1];
  assign s0_if.we  = r_we[0];   assign s1_if.we  = r_we[1];
  assign s0_if.tgd = 1'b0;      assign s1_if.tgd = 1'b1;
  assign s0_if.sel = r_sel[0];  assign s1_if.sel = r_sel[1];
  assign s0_if.addr = r_addr[0]; assign s1_if.addr = r_addr[1];
  assign s0_if.dat_o_p = r_dat[0]; assign s1_if.dat_o_p = r_dat[1];

  // RAM slave: acks BUSY_CYCLES+1 edges after it first sees cyc&stb, aborts on cyc=0
  logic [DW-1:0] mem [64];
  int unsigned   ram_cnt;
  logic          ram_ack;
  logic [DW-1:0] ram_rdata;

  assign m_if.ack     = ram_ack;
  assign m_if.dat_i_p = ram_rdata;

  initial for (int i = 0; i < 64; i++) mem[i] = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ram_cnt <= 0; ram_ack <= 1'b0; ram_rdata <= '0;
    end else if (!m_if.cyc) begin
      ram_cnt <= 0; ram_ack <= 1'b0;
    end else if (m_if.stb && !ram_ack) begin
      if (ram_cnt == BUSY_CYCLES) begin
        ram_ack <= 1'b1;
        ram_cnt <= 0;
        if (m_if.we) begin
          for (int b = 0; b < SW; b++)
            if (m_if.sel[b]) mem[m_if.addr[7:2]][b*8 +: 8] <= m_if.dat_o_p[b*8 +: 8];
        end else begin
          ram_rdata <= mem[m_if.addr[7:2]];
        end
      end else begin
        ram_cnt <= ram_cnt + 1;
      end
    end else begin
      ram_ack <= 1'b0;
    end
  end

  // monitor: grant change history, acks to non-owners, s1 ack count
  logic [1:0] grant_hist[$];
  logic [1:0] grant_prev = 2'b00;
  int misroute = 0;
  int s1_acks = 0;

  always @(negedge clock) begin
    if (s0_if.ack && grant != 2'b01) misroute++;
    if (s1_if.ack && grant != 2'b10) misroute++;
    if (grant == 2'b00 && (m_if.cyc || m_if.stb)) misroute++;
    if (s1_if.ack) s1_acks++;
    if (grant != grant_prev) begin
      grant_hist.push_back(grant);
      grant_prev = grant;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] hist_at(input int idx);
    if (idx < grant_hist.size()) return grant_hist[idx];
    return 2'b11;
  endfunction

  // lat = negedges waited until ack (-1 on timeout)
  task automatic txn(input int who, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    lat = -1;
    rdata = '0;
    @(posedge clock); #1;
    r_cyc[who] = 1'b1; r_stb[who] = 1'b1; r_we[who] = we;
    r_sel[who] = '1; r_addr[who] = addr; r_dat[who] = wdata;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (who == 0 ? s0_if.ack : s1_if.ack) begin
        lat = i;
        rdata = (who == 0) ? s0_if.dat_i_p : s1_if.dat_i_p;
        break;
      end
    end
    @(posedge clock); #1;
    r_cyc[who] = 1'b0; r_stb[who] = 1'b0; r_we[who] = 1'b0;
  endtask

  logic [31:0] rd0, rd1;
  int lat0, lat1, h0, s1_base, err0, err1, bad;
  logic [1:0] exp_g;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      r_cyc[i] = 1'b1; r_stb[i] = 1'b1; r_we[i] = 1'b0;
      r_sel[i] = '1; r_addr[i] = '0; r_dat[i] = '0;
    end

    // reset held with both requesting
    repeat (3) @(posedge clock);
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_m_cyc", m_if.cyc, 1'b0);
    check("rst_s0_ack", s0_if.ack, 1'b0);
    check("rst_s1_ack", s1_if.ack, 1'b0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    check("rel_grant", grant, 2'b01);
    check("rel_m_cyc", m_if.cyc, 1'b1);
    r_cyc[0] = 1'b0; r_stb[0] = 1'b0; r_cyc[1] = 1'b0; r_stb[1] = 1'b0;
    @(posedge clock); #1;
    check("rel_idle", grant, 2'b00);
    repeat (2) @(posedge clock);

    // s0 alone: write then read back
    s1_base = s1_acks;
    txn(0, 1'b1, 32'h8, 32'hDEADBEEF, rd0, lat0);
    check("s0_wr_lat", lat0, 8);
    txn(0, 1'b0, 32'h8, 32'h0, rd0, lat0);
    check("s0_rd_lat", lat0, 8);
    check("s0_rd_data", rd0, 32'hDEADBEEF);
    check("s1_no_ack", s1_acks - s1_base, 0);

    // preload, then simultaneous reads
    txn(0, 1'b1, 32'h0, 32'hA0A0A0A0, rd0, lat0);
    check("pre_s0_lat", lat0, 8);
    txn(1, 1'b1, 32'h4, 32'h5B5B5B5B, rd1, lat1);
    check("pre_s1_lat", lat1, 8);
    repeat (2) @(posedge clock);
    h0 = grant_hist.size();
    fork
      txn(0, 1'b0, 32'h0, 32'h0, rd0, lat0);
      txn(1, 1'b0, 32'h4, 32'h0, rd1, lat1);
    join
    repeat (2) @(posedge clock);
    check("sim_s0_data", rd0, 32'hA0A0A0A0);
    check("sim_s1_data", rd1, 32'h5B5B5B5B);
    check("sim_s0_lat", lat0, 8);
    check("sim_s1_lat", lat1, 18);
    check("sim_hist_len", grant_hist.size() - h0, 4);
    check("sim_hist0", hist_at(h0), 2'b01);
    check("sim_hist1", hist_at(h0 + 1), 2'b00);
    check("sim_hist2", hist_at(h0 + 2), 2'b10);

    // back-to-back contention, 8 each
    h0 = grant_hist.size();
    err0 = 0; err1 = 0;
    fork
      begin
        logic [31:0] d; int l;
        for (int k = 0; k < 8; k++) begin
          txn(0, 1'b0, 32'h0, 32'h0, d, l);
          if (d !== 32'hA0A0A0A0 || l < 0) err0++;
        end
      end
      begin
        logic [31:0] d; int l;
        for (int k = 0; k < 8; k++) begin
          txn(1, 1'b0, 32'h4, 32'h0, d, l);
          if (d !== 32'h5B5B5B5B || l < 0) err1++;
        end
      end
    join
    repeat (2) @(posedge clock);
    check("b2b_s0_data", err0, 0);
    check("b2b_s1_data", err1, 0);
    check("b2b_hist_len", grant_hist.size() - h0, 32);
    bad = 0;
    for (int k = 0; k < 16; k++) begin
`ifdef WB_ARBITER_FIXED_PRIORITY_EN
      exp_g = (k < 8) ? 2'b01 : 2'b10;
`else
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      if (hist_at(h0 + 2*k) !== exp_g) bad++;
      if (hist_at(h0 + 2*k + 1) !== 2'b00) bad++;
    end
    check("b2b_pattern", bad, 0);

    // reset while s1 owns the bus mid busy window
    @(posedge clock); #1;
    r_cyc[1] = 1'b1; r_stb[1] = 1'b1; r_we[1] = 1'b1;
    r_addr[1] = 32'h8; r_dat[1] = 32'h12345678;
    @(posedge clock); #1;
    check("mid_grant_s1", grant, 2'b10);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("mid_m_cyc", m_if.cyc, 1'b0);
    check("mid_m_stb", m_if.stb, 1'b0);
    check("mid_grant", grant, 2'b00);
    check("mid_s1_ack", s1_if.ack, 1'b0);
    r_cyc[1] = 1'b0; r_stb[1] = 1'b0; r_we[1] = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    txn(0, 1'b0, 32'h8, 32'h0, rd0, lat0);
    check("post_rst_lat", lat0, 8);
    check("post_rst_data", rd0, 32'hDEADBEEF);

    check("misroute", misroute, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
